tx_byte_serialiser: RTL and testbench

Synthesisable consumer of the byte side of `tx_interface`. It pulls bytes from the frame source through the `req` handshake and serialises them LSB-first into a single-bit stream for the downstream bit encoder (Manchester/load modulation). It appends an ISO/IEC 14443A odd parity bit after every byte and supports a partial first byte for bit-oriented anticollision frames. It sits between the frame builder (or the bench source) and the encoder in the PICC transmit path.

---
 rtl/tx_serialiser_pkg.sv | 21 ++
 rtl/tx_bit_shifter.sv | 58 +++++
 rtl/tx_byte_serialiser.sv | 171 +++++++++++++++++
 tb/tb_tx_byte_serialiser.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tx_serialiser_pkg.sv
// tx_serialiser_pkg
// Shared definitions for the ISO/IEC 14443A transmit byte serialiser:
//   tx_ser_state_t : serialiser FSM states (IDLE, DATA, PARITY)
//   BITS_PER_BYTE  : width of one transmitted byte
//   odd_parity()   : ISO 14443A odd parity bit for a byte
package tx_serialiser_pkg;

    localparam int unsigned BITS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } tx_ser_state_t;

    // Odd parity: the returned bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [BITS_PER_BYTE-1:0] byte_in);
        return ~^byte_in;
    endfunction

endpackage

// File: rtl/tx_bit_shifter.sv
// tx_bit_shifter
// Byte holding register with a 3-bit bit index and the output bit mux.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   load        : capture load_data and load_idx
//   load_data   : byte to hold for transmission
//   load_idx    : index of the first bit to transmit
//   advance     : step the bit index by one
//   sel_parity  : present the odd parity of the held byte instead of a data bit
//   bit_idx     : current bit index
//   cur_bit     : selected data bit or parity bit
module tx_bit_shifter
    import tx_serialiser_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [BITS_PER_BYTE-1:0] load_data,
    input  logic [2:0]               load_idx,
    input  logic                     advance,
    input  logic                     sel_parity,
    output logic [2:0]               bit_idx,
    output logic                     cur_bit
);

    logic [BITS_PER_BYTE-1:0] shreg_q, shreg_d;
    logic [2:0]               idx_q, idx_d;

    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (load) begin
            shreg_d = load_data;
            idx_d   = load_idx;
        end else if (advance) begin
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    // Parity covers all eight held bits, including any not transmitted
    // from a partial first byte.
    always_comb begin
        cur_bit = sel_parity ? odd_parity(shreg_q) : shreg_q[idx_q];
    end

    assign bit_idx = idx_q;

endmodule

// File: rtl/tx_byte_serialiser.sv
// tx_byte_serialiser
// Pulls bytes from the frame source via the in_req handshake and serialises
// them LSB-first for the bit encoder, optionally appending an odd parity bit
// after each byte. The first byte of a frame may be partial (in_data_bits).
// Optional feature macro: ISO14443A_TX_PARITY_EN (parity bit after every byte).
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   in_data        : byte presented by the source
//   in_data_bits   : valid bits in the first byte of a frame (0 = 8)
//   in_data_valid  : source has a byte to send
//   in_req         : pulse, in_data is captured this cycle
//   out_bit        : current serial bit
//   out_valid      : out_bit is valid
//   out_last       : out_bit is the final bit of the frame
//   out_req        : pulse from encoder, current bit consumed
//   busy           : frame in progress
module tx_byte_serialiser
    import tx_serialiser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [2:0]            in_data_bits,
    input  logic                  in_data_valid,
    output logic                  in_req,
    output logic                  out_bit,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_req,
    output logic                  busy
);

    if (DATA_WIDTH != BITS_PER_BYTE) begin : g_bad_width
        $error("tx_byte_serialiser supports DATA_WIDTH = 8 only");
    end

    tx_ser_state_t state_q, state_d;

    logic       active;
    logic       accept;
    logic       load;
    logic       load_first;
    logic       advance;
    logic       byte_done;
    logic       final_bit;
    logic       req_c;
    logic [3:0] first_bits;
    logic [2:0] first_idx;
    logic [2:0] load_idx;
    logic [2:0] bit_idx;
    logic       cur_bit;
    logic       sel_parity;

    assign active = (state_q != IDLE);
    assign accept = out_req && active;

    // A partial first byte of N bits starts at bit 8-N so its top N bits go out.
    always_comb begin
        first_bits = (in_data_bits == 3'd0) ? 4'd8 : {1'b0, in_data_bits};
        first_idx  = 3'(4'(BITS_PER_BYTE) - first_bits);
        load_idx   = load_first ? first_idx : '0;
    end

    always_comb begin
        state_d    = state_q;
        req_c      = 1'b0;
        load       = 1'b0;
        load_first = 1'b0;
        advance    = 1'b0;
        byte_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_data_valid) begin
                    req_c      = 1'b1;
                    load       = 1'b1;
                    load_first = 1'b1;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    if (bit_idx != 3'd7) begin
                        advance = 1'b1;
                    end else begin
`ifdef ISO14443A_TX_PARITY_EN
                        state_d = PARITY;
`else
                        byte_done = 1'b1;
`endif
                    end
                end
            end
`ifdef ISO14443A_TX_PARITY_EN
            PARITY: begin
                if (accept) begin
                    byte_done = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Byte turnover: either chain straight into the next byte or end the frame.
        if (byte_done) begin
            if (in_data_valid) begin
                req_c   = 1'b1;
                load    = 1'b1;
                state_d = DATA;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign sel_parity = (state_q == PARITY);

    tx_bit_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (in_data),
        .load_idx   (load_idx),
        .advance    (advance),
        .sel_parity (sel_parity),
        .bit_idx    (bit_idx),
        .cur_bit    (cur_bit)
    );

`ifdef ISO14443A_TX_PARITY_EN
    assign final_bit = (state_q == PARITY);
`else
    assign final_bit = (state_q == DATA) && (bit_idx == 3'd7);
`endif

    // in_req is combinational so the source sees it in the sampling cycle;
    // it is held low while reset is asserted.
    assign in_req    = req_c && !rst;
    assign out_valid = active;
    assign busy      = active;
    assign out_bit   = active && cur_bit;
    assign out_last  = final_bit && !in_data_valid;

`ifndef SYNTHESIS
    // out_req pulses must be at least three cycles apart.
    logic [1:0] req_hist_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_hist_q <= '0;
        end else begin
            req_hist_q <= {req_hist_q[0], out_req};
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && out_req) begin
            assert (req_hist_q == 2'b00);
        end
    end
`endif

endmodule

// File: tb/tb_tx_byte_serialiser.sv
module tb_tx_byte_serialiser;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic [2:0] in_data_bits;
    logic       in_data_valid;
    logic       in_req;
    logic       out_bit;
    logic       out_valid;
    logic       out_last;
    logic       out_req;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] frame_q[$];
    logic [2:0] frame_bits;

    always #5 clk = ~clk;

    tx_byte_serialiser #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_data_bits  (in_data_bits),
        .in_data_valid (in_data_valid),
        .in_req        (in_req),
        .out_bit       (out_bit),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .out_req       (out_req),
        .busy          (busy)
    );

`ifdef ISO14443A_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    task automatic check_idle_outputs(input string name);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid got %b exp 0", name, out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b exp 0", name, busy); end
        checks++;
        if (in_req !== 1'b0) begin errors++; $display("FAIL %s in_req got %b exp 0", name, in_req); end
        checks++;
        if (out_bit !== 1'b0) begin errors++; $display("FAIL %s out_bit got %b exp 0", name, out_bit); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL %s out_last got %b exp 0", name, out_last); end
    endtask

    // Drives frame_q through the DUT as source and encoder, checking every cycle
    // against a bit list derived from the frame contents.
    task automatic run_frame(input string name);
        logic        exp_bits[$];
        logic        exp_end[$];
        logic        exp_lst[$];
        int unsigned n, start, size, nbytes, pos, captured, gap, target;
        logic        req_prev, acc_prev, exp_valid, exp_req, done, pbit, exp_b, exp_l;

        n      = (frame_bits == 3'd0) ? 8 : int'(frame_bits);
        nbytes = frame_q.size();
        for (int unsigned i = 0; i < nbytes; i++) begin
            start = (i == 0) ? 8 - n : 0;
            for (int unsigned k = start; k < 8; k++) begin
                exp_bits.push_back(frame_q[i][k]);
                exp_end.push_back(!PAR_EN && k == 7);
                exp_lst.push_back(1'b0);
            end
            if (PAR_EN) begin
                pbit = ($countones(frame_q[i]) % 2) == 0;
                exp_bits.push_back(pbit);
                exp_end.push_back(1'b1);
                exp_lst.push_back(1'b0);
            end
        end
        size = exp_bits.size();
        exp_lst[size-1] = 1'b1;

        pos = 0; captured = 0; gap = 0; target = $urandom_range(3, 6);
        req_prev = 1'b0; acc_prev = 1'b0; done = 1'b0;

        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(posedge clk); #1;
            if (req_prev) captured++;
            if (acc_prev) pos++;
            if (out_req) gap = 1; else gap++;
            out_req       = 1'b0;
            in_data_valid = captured < nbytes;
            if (captured < nbytes && (captured == 0 || (pos < size && exp_end[pos])))
                in_data = frame_q[captured];
            else
                in_data = 8'($urandom);
            in_data_bits = (captured > 0) ? 3'($urandom) : frame_bits;
            exp_valid = captured > 0 && pos < size;
            if (exp_valid && gap >= target) begin
                out_req = 1'b1;
                target  = $urandom_range(3, 6);
            end

            @(negedge clk);
            exp_req = in_data_valid && (captured == 0 || (out_req && exp_end[pos]));
            exp_b   = exp_valid ? exp_bits[pos] : 1'b0;
            exp_l   = exp_valid ? exp_lst[pos] : 1'b0;
            checks++;
            if (out_valid !== exp_valid) begin errors++; $display("FAIL %s cyc%0d out_valid got %b exp %b", name, cyc, out_valid, exp_valid); end
            checks++;
            if (busy !== exp_valid) begin errors++; $display("FAIL %s cyc%0d busy got %b exp %b", name, cyc, busy, exp_valid); end
            checks++;
            if (in_req !== exp_req) begin errors++; $display("FAIL %s cyc%0d in_req got %b exp %b", name, cyc, in_req, exp_req); end
            checks++;
            if (out_bit !== exp_b) begin errors++; $display("FAIL %s cyc%0d pos%0d out_bit got %b exp %b", name, cyc, pos, out_bit, exp_b); end
            checks++;
            if (out_last !== exp_l) begin errors++; $display("FAIL %s cyc%0d pos%0d out_last got %b exp %b", name, cyc, pos, out_last, exp_l); end
            req_prev = exp_req;
            acc_prev = out_req;
            done     = captured > 0 && pos >= size;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL %s timeout got pos %0d exp %0d", name, pos, size); end
        @(posedge clk); #1;
        out_req       = 1'b0;
        in_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_data = '0; in_data_bits = '0; in_data_valid = 1'b0; out_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single_a5;
        frame_q = {8'hA5}; frame_bits = 3'd0;
        run_frame("single_a5");
    endtask

    task automatic test_back_to_back;
        frame_q = {8'h01, 8'hFF}; frame_bits = 3'd0;
        run_frame("two_bytes");
    endtask

    task automatic test_partial_first;
        frame_q = {8'hE0, 8'h00}; frame_bits = 3'd3;
        run_frame("partial_first");
    endtask

    task automatic test_reset_mid_byte;
        in_data = 8'hB5; in_data_bits = 3'd0; in_data_valid = 1'b1;
        @(posedge clk); #1;
        in_data_valid = 1'b0;
        repeat (4) begin
            repeat (2) begin @(posedge clk); #1; end
            out_req = 1'b1;
            @(posedge clk); #1;
            out_req = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (out_bit !== 1'b1) begin errors++; $display("FAIL rst_mid pre out_bit got %b exp 1", out_bit); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid pre out_valid got %b exp 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid_async");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        frame_q = {8'h3C}; frame_bits = 3'd0;
        run_frame("after_reset_3c");
    endtask

    task automatic test_idle_req;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom);
            out_req = 1'b1;
            @(negedge clk);
            check_idle_outputs("idle_out_req");
            @(posedge clk); #1;
            out_req = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random_frames;
        for (int f = 0; f < 8; f++) begin
            frame_q.delete();
            for (int b = 0; b < int'($urandom_range(1, 4)); b++) frame_q.push_back(8'($urandom));
            frame_bits = 3'($urandom);
            run_frame($sformatf("random%0d", f));
        end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_partial_first();
        test_reset_mid_byte();
        test_idle_req();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
